// File: rtl/gc_resp_decoder.sv
// -----------------------------------------------------------------------------
// gc_resp_decoder
//
// Receive side of the GameCube controller link. Once the poll generator has
// sent its command and released the line (signalled by a one-cycle 'arm'
// pulse), this block watches the synchronised data line and decodes the
// controller's 64-bit response plus its stop bit. Each bit starts with a
// falling edge; the line is sampled 2 us later: still low means '0', already
// high means '1'.
//
// Optional build macro:
//   GC_RESP_GLITCH_FILTER_EN - when defined, a 3-tap majority filter follows
//                              the 2-flop synchroniser, so single-cycle
//                              glitches are rejected. Input latency becomes
//                              4 cycles instead of 2. Thresholds are unchanged.
//
// Ports:
//   clk          in   system clock (~58-60 MHz)
//   reset        in   synchronous, active-high reset
//   arm          in   one-cycle pulse: start (or restart) reception
//   gc_data_in   in   raw asynchronous data line, idle high
//   frame_data   out  [NUM_BITS] last good frame, first received bit in MSB
//   frame_valid  out  one-cycle strobe, frame_data updated in the same cycle
//   frame_error  out  one-cycle strobe on any aborted reception
//   busy         out  high in every state except IDLE
//   bit_count    out  [7] data bits captured in the current frame
//   o_dbg_state  out  [3] current FSM state encoding, for observation only
//
// Output protocol: there is no back-pressure. frame_valid and frame_error are
// single-cycle strobes that the consumer must take when they occur; they are
// never high together. frame_data changes only in the cycle frame_valid is
// high and holds across errors.
// -----------------------------------------------------------------------------
module gc_resp_decoder #(
  parameter int CLKS_PER_US        = 58,
  parameter int NUM_BITS           = 64,
  parameter int SAMPLE_CLKS        = 2 * CLKS_PER_US,
  parameter int LOW_MAX_CLKS       = (7 * CLKS_PER_US) / 2,
  parameter int EDGE_TIMEOUT_CLKS  = 8 * CLKS_PER_US,
  parameter int START_TIMEOUT_CLKS = 200 * CLKS_PER_US
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                arm,
  input  logic                gc_data_in,
  output logic [NUM_BITS-1:0] frame_data,
  output logic                frame_valid,
  output logic                frame_error,
  output logic                busy,
  output logic [6:0]          bit_count,
  output logic [2:0]          o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_LOW        = 3'd2,
    S_WAIT_EDGE  = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  localparam logic [13:0] SAMPLE_T   = 14'(SAMPLE_CLKS);
  localparam logic [13:0] LOW_MAX_T  = 14'(LOW_MAX_CLKS);
  localparam logic [13:0] EDGE_TO_T  = 14'(EDGE_TIMEOUT_CLKS);
  localparam logic [13:0] START_TO_T = 14'(START_TIMEOUT_CLKS);
  localparam logic [6:0]  NUM_BITS_C = 7'(NUM_BITS);

  // ---------------------------------------------------------------------------
  // Input synchronisation. Flops reset to 1 (idle line level) so leaving
  // reset never looks like a falling edge.
  // ---------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic w_line_s;
  logic r_line_prev;
  logic w_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= gc_data_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef GC_RESP_GLITCH_FILTER_EN
  // Majority of the last three synchronised samples, registered. A one-cycle
  // excursion is never in two of the three taps at once, so it is dropped.
  logic r_hist1;
  logic r_hist2;
  logic r_filt;
  logic w_maj;

  assign w_maj = (r_sync2 & r_hist1) | (r_sync2 & r_hist2) | (r_hist1 & r_hist2);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist1 <= 1'b1;
      r_hist2 <= 1'b1;
      r_filt  <= 1'b1;
    end else begin
      r_hist1 <= r_sync2;
      r_hist2 <= r_hist1;
      r_filt  <= w_maj;
    end
  end

  assign w_line_s = r_filt;
`else
  assign w_line_s = r_sync2;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_line_prev <= 1'b1;
    end else begin
      r_line_prev <= w_line_s;
    end
  end

  assign w_fall = r_line_prev & ~w_line_s;

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_nxt;
  logic [13:0]         r_timer;
  logic [13:0]         w_timer_nxt;
  logic [13:0]         w_timer_inc;
  logic [NUM_BITS-1:0] r_shift;
  logic [NUM_BITS-1:0] w_shift_nxt;
  logic [6:0]          r_bit_count;
  logic [6:0]          w_count_nxt;
  logic [NUM_BITS-1:0] r_frame_data;
  logic                r_frame_valid;
  logic                r_frame_error;
  logic                w_valid_nxt;
  logic                w_error_nxt;

  // Saturating increment: the timer parks at all-ones instead of wrapping.
  assign w_timer_inc = (r_timer == 14'h3FFF) ? r_timer : (r_timer + 14'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_shift       <= '0;
      r_bit_count   <= '0;
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_timer       <= w_timer_nxt;
      r_shift       <= w_shift_nxt;
      r_bit_count   <= w_count_nxt;
      r_frame_valid <= w_valid_nxt;
      r_frame_error <= w_error_nxt;
      // The frame is published on the same edge that enters DONE, so
      // frame_valid is high exactly for the single cycle spent in DONE.
      if (w_valid_nxt) begin
        r_frame_data <= r_shift;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_shift_nxt = r_shift;
    w_count_nxt = r_bit_count;
    w_valid_nxt = 1'b0;
    w_error_nxt = 1'b0;

    if (arm) begin
      // Arm from any state restarts cleanly; a partial frame is dropped
      // silently.
      w_state_nxt = S_WAIT_START;
      w_timer_nxt = '0;
      w_shift_nxt = '0;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_timer_nxt = '0;
        end

        S_WAIT_START: begin
          if (w_fall) begin
            w_state_nxt = S_LOW;
            w_timer_nxt = '0;
          end else if (r_timer >= START_TO_T) begin
            w_state_nxt = S_IDLE;
            w_error_nxt = 1'b1;
          end else begin
            w_timer_nxt = w_timer_inc;
          end
        end

        S_LOW: begin
          w_timer_nxt = w_timer_inc;
          if (r_timer == SAMPLE_T) begin
            if (r_bit_count < NUM_BITS_C) begin
              w_shift_nxt = {r_shift[NUM_BITS-2:0], w_line_s};
              w_count_nxt = r_bit_count + 7'd1;
              w_state_nxt = S_WAIT_EDGE;
            end else if (w_line_s) begin
              // Stop bit must be a short-low ('1') symbol.
              w_state_nxt = S_DONE;
              w_valid_nxt = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
              w_error_nxt = 1'b1;
            end
          end
        end

        S_WAIT_EDGE: begin
          // The next bit's edge normally lands after LOW_MAX (a bit is 4 us),
          // so the edge check must win over the stuck-low check.
          if (w_fall) begin
            w_state_nxt = S_LOW;
            w_timer_nxt = '0;
          end else if (!w_line_s && (r_timer > LOW_MAX_T)) begin
            w_state_nxt = S_IDLE;
            w_error_nxt = 1'b1;
          end else if (r_timer >= EDGE_TO_T) begin
            w_state_nxt = S_IDLE;
            w_error_nxt = 1'b1;
          end else begin
            w_timer_nxt = w_timer_inc;
          end
        end

        S_DONE: begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  assign frame_data  = r_frame_data;
  assign frame_valid = r_frame_valid;
  assign frame_error = r_frame_error;
  assign busy        = (r_state != S_IDLE);
  assign bit_count   = r_bit_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_gc_resp_decoder.sv
// -----------------------------------------------------------------------------
// tb_gc_resp_decoder
//
// Directed bench for gc_resp_decoder. The pad is driven with GameCube bit
// symbols (4 us per bit: '1' = 1 us low / 3 us high, '0' = 3 us low / 1 us
// high). Every frame outcome (good frame with its data, or error) is pushed
// onto exp_q before the stimulus is sent; a negedge monitor pops and compares
// whenever frame_valid or frame_error strobes. Latency checks count clock
// edges from the edge after which the pad was changed.
// -----------------------------------------------------------------------------
module tb_gc_resp_decoder;

  localparam int CLKS_PER_US        = 58;
  localparam int NUM_BITS           = 64;
  localparam int SAMPLE_CLKS        = 116;
  localparam int LOW_MAX_CLKS       = 203;
  localparam int EDGE_TIMEOUT_CLKS  = 464;
  localparam int START_TIMEOUT_CLKS = 11600;
  localparam int ONE_LOW            = CLKS_PER_US;
  localparam int ZERO_LOW           = 3 * CLKS_PER_US;

`ifdef GC_RESP_GLITCH_FILTER_EN
  localparam int IN_LAT = 4;
`else
  localparam int IN_LAT = 2;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic        arm;
  logic        gc_data_in;
  logic [63:0] frame_data;
  logic        frame_valid;
  logic        frame_error;
  logic        busy;
  logic [6:0]  bit_count;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  gc_resp_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .arm         (arm),
    .gc_data_in  (gc_data_in),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_error (frame_error),
    .busy        (busy),
    .bit_count   (bit_count),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [64:0] exp_q[$];   // bit 64: 1 = error expected, [63:0] = frame data
  logic [64:0] mon_got;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && (frame_valid === 1'b1 || frame_error === 1'b1)) begin
      check("valid_error_exclusive", 64'(frame_valid & frame_error), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse_queue_size", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_got = exp_q.pop_front();
        check("pulse_kind_error", 64'(frame_error), 64'(mon_got[64]));
        if (frame_valid === 1'b1) begin
          check("scoreboard_frame_data", frame_data, mon_got[63:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all start and end 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // glitch_at > 0 drops the line for one cycle at that offset into the high phase
  task automatic send_bit(input logic b, input int glitch_at);
    int lo;
    int hi;
    lo = b ? ONE_LOW : ZERO_LOW;
    hi = b ? ZERO_LOW : ONE_LOW;
    gc_data_in = 1'b0;
    repeat (lo) tick();
    for (int j = 0; j < hi; j++) begin
      gc_data_in = (glitch_at > 0 && j == glitch_at) ? 1'b0 : 1'b1;
      tick();
    end
    gc_data_in = 1'b1;
  endtask

  task automatic send_bits(input logic [63:0] data, input int count, input int glitch_bit);
    for (int i = 0; i < count; i++) begin
      send_bit(data[63 - i], (i == glitch_bit) ? 30 : 0);
    end
  endtask

  // Start a bit by pulling the pad low, release after low_cycles, and report
  // how many edges later the watched strobe appeared (-1 if never).
  task automatic drive_and_watch(input int low_cycles, input bit want_err,
                                 input int budget, output int lat);
    lat = -1;
    gc_data_in = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (k == low_cycles) gc_data_in = 1'b1;
      if ((want_err ? frame_error : frame_valid) === 1'b1) begin
        lat = k;
        break;
      end
    end
    gc_data_in = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_frame_data"}, frame_data, 64'd0);
    check({tag, "_frame_valid"}, 64'(frame_valid), 64'd0);
    check({tag, "_frame_error"}, 64'(frame_error), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_bit_count"}, 64'(bit_count), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  logic [63:0] d1;
  logic [63:0] d2;
  logic [63:0] d3;
  logic [63:0] d4;
  int          lat;
  int          glitch_bit;

  initial begin
    d1 = 64'h0080_8080_8080_0000;
    d2 = {$urandom, $urandom};
    d3 = {$urandom, $urandom};
    d4 = {$urandom, $urandom};
`ifdef GC_RESP_GLITCH_FILTER_EN
    glitch_bit = 5;
`else
    glitch_bit = -1;
`endif

    reset = 1'b1;
    arm = 1'b0;
    gc_data_in = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    repeat (5) tick();

    // Valid frame
    do_arm();
    check("armed_busy", 64'(busy), 64'd1);
    repeat (40) tick();
    exp_q.push_back({1'b0, d1});
    send_bits(d1, 64, -1);
    drive_and_watch(ONE_LOW, 1'b0, 300, lat);
    check("valid_latency", 64'(lat), 64'(IN_LAT + SAMPLE_CLKS + 2));
    check("valid_frame_data", frame_data, d1);
    tick();
    check("valid_bit_count", 64'(bit_count), 64'd64);
    check("valid_busy_after", 64'(busy), 64'd0);
    repeat (200) tick();

    // No response: start timeout
    exp_q.push_back({1'b1, 64'd0});
    arm = 1'b1;
    lat = -1;
    for (int k = 1; k <= START_TIMEOUT_CLKS + 400; k++) begin
      tick();
      if (k == 1) arm = 1'b0;
      if (frame_error === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("start_timeout_latency", 64'(lat), 64'(START_TIMEOUT_CLKS + 2));
    tick();
    check("start_timeout_busy", 64'(busy), 64'd0);
    check("start_timeout_frame_data", frame_data, d1);
    repeat (20) tick();

    // Stuck low after 10 good bits (11th held low 5 us)
    do_arm();
    repeat (40) tick();
    exp_q.push_back({1'b1, 64'd0});
    send_bits(d2, 10, -1);
    drive_and_watch(5 * CLKS_PER_US, 1'b1, 400, lat);
    check("stuck_low_latency", 64'(lat), 64'(IN_LAT + 1 + (LOW_MAX_CLKS + 1) + 1));
    tick();
    check("stuck_low_busy", 64'(busy), 64'd0);
    repeat (200) tick();

    // Truncated frame: 40 bits then idle high
    do_arm();
    repeat (40) tick();
    exp_q.push_back({1'b1, 64'd0});
    send_bits(d2, 39, -1);
    drive_and_watch(d2[24] ? ONE_LOW : ZERO_LOW, 1'b1, 700, lat);
    check("truncated_latency", 64'(lat), 64'(IN_LAT + EDGE_TIMEOUT_CLKS + 2));
    check("truncated_bit_count", 64'(bit_count), 64'd40);
    check("truncated_frame_data", frame_data, d1);
    repeat (20) tick();

    // Bad stop bit (long low)
    do_arm();
    repeat (40) tick();
    exp_q.push_back({1'b1, 64'd0});
    send_bits(d3, 64, -1);
    drive_and_watch(ZERO_LOW, 1'b1, 300, lat);
    check("bad_stop_latency", 64'(lat), 64'(IN_LAT + SAMPLE_CLKS + 2));
    check("bad_stop_frame_data", frame_data, d1);
    repeat (200) tick();

    // Re-arm while busy, then reset at bit 30, then re-arm for a full frame
    do_arm();
    repeat (40) tick();
    send_bits(d3, 20, -1);
    do_arm();
    check("rearm_bit_count", 64'(bit_count), 64'd0);
    check("rearm_busy", 64'(busy), 64'd1);
    repeat (40) tick();
    send_bits(d3, 30, -1);
    reset = 1'b1;
    tick();
    check_all_zero("midframe_reset");
    reset = 1'b0;
    tick();
    do_arm();
    repeat (40) tick();
    exp_q.push_back({1'b0, d4});
    send_bits(d4, 64, glitch_bit);
    drive_and_watch(ONE_LOW, 1'b0, 300, lat);
    check("rearm_valid_latency", 64'(lat), 64'(IN_LAT + SAMPLE_CLKS + 2));
    check("rearm_frame_data", frame_data, d4);
    check("rearm_bit_count_64", 64'(bit_count), 64'd64);
    repeat (200) tick();

`ifndef GC_RESP_GLITCH_FILTER_EN
    // Unfiltered: a single-cycle low is a real falling edge, decoded as '1'
    do_arm();
    repeat (40) tick();
    exp_q.push_back({1'b1, 64'd0});
    gc_data_in = 1'b0;
    tick();
    gc_data_in = 1'b1;
    repeat (150) tick();
    check("single_pulse_bit_count", 64'(bit_count), 64'd1);
    repeat (500) tick();
`endif

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gc_resp_decoder.md
Name: gc_resp_decoder

Overview:
- Receive side of the GameCube controller link.
- After the poll generator finishes sending the 0x400300 poll command and releases the line, this block listens on the synchronised data line and decodes the controller's 64-bit response plus its stop bit.
- It presents the captured frame as a parallel word with a one-cycle valid strobe, or flags an error.
- It sits between the open-drain pad input and the USB report builder.

Parameters:
- CLKS_PER_US, 58: clock cycles per 1 us chip, matching the poll generator's chip timing.
- NUM_BITS, 64: data bits per response, not counting the stop bit.
- SAMPLE_CLKS, 116: cycles from a falling edge to the bit sample point (2 us).
- LOW_MAX_CLKS, 203: maximum legal continuous low time (3.5 us). Exceeding it is an error.
- EDGE_TIMEOUT_CLKS, 464: maximum cycles between consecutive falling edges inside a frame (8 us).
- START_TIMEOUT_CLKS, 11600: maximum wait for the first falling edge after arming (200 us).

Ports:
- clk, input, 1: system clock (~58-60 MHz).
- reset, input, 1: synchronous, active-high reset.
- arm, input, 1: one-cycle pulse from the poll generator when it releases the line (GC_enable rising). Starts reception.
- gc_data_in, input, 1: raw data line, asynchronous. Idle high.
- frame_data, output, NUM_BITS: last good frame. The first received bit goes to the MSB.
- frame_valid, output, 1: one-cycle pulse when frame_data is updated.
- frame_error, output, 1: one-cycle pulse on any abort.
- busy, output, 1: high in every state except IDLE.
- bit_count, output, 7: number of data bits captured in the current frame.

Behaviour:
- Input synchronisation:
  - gc_data_in passes through a 2-flop synchroniser, giving line_s.
  - A falling edge is line_s going 1 to 0 between consecutive cycles.
  - All timing below is measured on line_s.
- Reset:
  - State goes to IDLE.
  - frame_data = 0, frame_valid = 0, frame_error = 0, busy = 0, bit_count = 0.
  - Timers and shift register are cleared.
  - Reset mid-frame discards the partial frame; no error pulse is produced.
- States:
  - IDLE: ignore the line. On arm, go to WAIT_START with the timer cleared.
  - WAIT_START: on a falling edge, go to LOW with timer = 0. If the timer reaches START_TIMEOUT_CLKS, pulse frame_error and go to IDLE.
  - LOW: the timer counts from the edge. At timer == SAMPLE_CLKS, sample line_s.
    - line_s = 1 is a '1' bit (1 us low, 3 us high).
    - line_s = 0 is a '0' bit (3 us low, 1 us high).
    - If bit_count < NUM_BITS: shift the bit in (left shift, LSB enters) and increment bit_count.
    - If bit_count == NUM_BITS, the edge was the stop bit. The sample must be 1. If so, go to DONE; otherwise pulse frame_error and go to IDLE.
    - After a data-bit sample, go to WAIT_EDGE. The timer keeps running from the falling edge.
  - WAIT_EDGE:
    - If line_s is low while timer > LOW_MAX_CLKS, pulse frame_error and go to IDLE.
    - On a falling edge (only possible after the line has returned high), restart the timer and go to LOW.
    - If the timer reaches EDGE_TIMEOUT_CLKS, pulse frame_error and go to IDLE.
  - DONE: for exactly one cycle, copy the shift register to frame_data and pulse frame_valid. Then go to IDLE.
- Latency: frame_valid asserts 2 (synchroniser) + SAMPLE_CLKS + 2 cycles after the stop-bit falling edge on the pad.
- arm while busy: restart from WAIT_START and discard the partial frame. No error pulse.
- frame_valid and frame_error are never high in the same cycle.
- frame_data holds its value across errors; it is updated only on frame_valid.
- Timer width: 14 bits, saturating. It never wraps.

Optional Feature:
- Macro: GC_RESP_GLITCH_FILTER_EN.
- Defined: a 3-tap majority filter follows the synchroniser. line_s becomes the majority of the last 3 synchronised samples, so single-cycle glitches are rejected. Total input latency is 4 cycles instead of 2, and the frame_valid latency grows by 2. All thresholds are unchanged.
- Not defined: no filter; a single-cycle low pulse counts as a falling edge.

Test Plan:
- Valid frame: arm, then drive 64 bits of 0x0080_8080_8080_0000 (MSB first, 4 us per bit, 1 us/3 us low) plus a stop bit. Required: one frame_valid pulse, frame_data = 64'h0080808080800000, bit_count = 64, no frame_error.
- No response: arm, line held high for 250 us. Required: frame_error pulses at START_TIMEOUT_CLKS + 2 cycles after arm; busy drops the next cycle; frame_data unchanged.
- Stuck low: after 10 valid bits, hold the line low for 5 us. Required: frame_error at timer = LOW_MAX_CLKS + 1; state returns to IDLE.
- Truncated frame: send 40 bits, then leave the line idle high. Required: frame_error 464 cycles after the 40th falling edge; frame_data keeps its previous value.
- Bad stop bit: 64 valid bits, then a 3 us-low stop bit. Required: frame_error pulse, no frame_valid.
- Reset and re-arm: assert reset at bit 30, then re-arm and send a full frame. Required: all outputs zero right after reset, then a correct frame_valid. With GC_RESP_GLITCH_FILTER_EN defined, inject a 1-cycle low glitch during a high phase; the frame must still decode correctly.
